// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and types for the register-file writeback path
package rf_pkg;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NREG = 9;
  localparam int ACC_IDX = 8;
  localparam int QDEPTH = 4;
  typedef logic [AW-1:0] reg_idx_t;
  typedef logic [DW-1:0] data_t;
  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM} wb_src_e;
endpackage

// File: rtl/rf_writeback_ld_tag_fifo.sv
// ld_tag_fifo: in-order queue of pending load destination registers
module ld_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  assign head = mem[rd];
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  // storage needs no reset; only entries between rd and wr are ever read
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + PW'(1);
      if (pop) rd <= rd + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: merges ALU results and load returns onto the register-file write port
import rf_pkg::*;
module rf_writeback #(
  parameter int QDEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_dst,
  input  logic [DW-1:0]   alu_data,
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_dst,
  input  logic            mem_valid,
  input  logic [DW-1:0]   mem_data,
  output logic            mem_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_ptr_w,
  output logic [DW-1:0]   rf_di,
  output logic [NREG-1:0] busy,
  output logic            ld_full,
  output logic            err
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int RS = 1 << AW;
  reg_idx_t head;
  logic [CW-1:0] count;
  logic fifo_full, empty, push, pop;
  logic [NREG-1:0] clr, set, busy_eff;
  logic [RS-1:0] busy_x, busy_eff_x;
  logic ld_ok, alu_ok, ld_busy, alu_busy, can_push, err_now;
  wb_src_e src;

  ld_tag_fifo #(.DEPTH(QDEPTH), .W(AW)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(ld_dst),
    .head(head), .count(count), .full(fifo_full), .empty(empty)
  );

  assign ld_full = count == CW'(QDEPTH);

  // arbitration, scoreboard update and error detection; a returning load clears its
  // busy bit before the issue check so a same-register reissue is accepted
  always_comb begin
    mem_ready = !alu_valid && !empty;
    pop = mem_valid && mem_ready;
    clr = pop ? NREG'(1) << head : '0;
    busy_eff = busy & ~clr;
    busy_x = RS'(busy);
    busy_eff_x = RS'(busy_eff);
    ld_ok = ld_dst < AW'(NREG);
    alu_ok = alu_dst < AW'(NREG);
    ld_busy = busy_eff_x[ld_dst];
    alu_busy = busy_x[alu_dst];
    can_push = !fifo_full || pop;
    push = ld_issue && ld_ok && can_push && !ld_busy;
    set = push ? NREG'(1) << ld_dst : '0;
    err_now = (ld_issue && !(ld_ok && can_push && !ld_busy)) ||
              (alu_valid && (!alu_ok || alu_busy)) || (mem_valid && empty);
    src = (alu_valid && alu_ok) ? WB_ALU : pop ? WB_MEM : WB_NONE;
  end

  // registered write port, busy scoreboard and sticky error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_ptr_w <= '0;
      rf_di <= '0;
      busy <= '0;
      err <= 1'b0;
    end else begin
      rf_we <= src != WB_NONE;
      rf_ptr_w <= src == WB_ALU ? alu_dst : src == WB_MEM ? head : rf_ptr_w;
      rf_di <= src == WB_ALU ? alu_data : src == WB_MEM ? mem_data : rf_di;
      busy <= busy_eff | set;
      err <= err | err_now;
    end
endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: directed table, reset corner cases and randomized model checking
module tb_rf_writeback;
  import rf_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic alu_valid = 1'b0, ld_issue = 1'b0, mem_valid = 1'b0;
  logic [AW-1:0] alu_dst = '0, ld_dst = '0;
  logic [DW-1:0] alu_data = '0, mem_data = '0;
  logic mem_ready, rf_we, ld_full, err;
  logic [AW-1:0] rf_ptr_w;
  logic [DW-1:0] rf_di;
  logic [NREG-1:0] busy;

  rf_writeback dut (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_dst(ld_dst), .mem_valid(mem_valid), .mem_data(mem_data),
    .mem_ready(mem_ready), .rf_we(rf_we), .rf_ptr_w(rf_ptr_w), .rf_di(rf_di),
    .busy(busy), .ld_full(ld_full), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;

  int q[$];
  logic [8:0] m_busy;
  logic m_we, m_err;
  logic [3:0] m_ptr;
  logic [7:0] m_di;

  typedef struct {
    logic rst, av; logic [3:0] ad; logic [7:0] adat;
    logic li; logic [3:0] ld; logic mv; logic [7:0] md;
    logic rdy, we; logic [3:0] ptr; logic [7:0] di; logic [8:0] bsy; logic full, er;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int rst, av, ad, adat, li, ld, mv, md,
                     rdy, we, ptr, di, bsy, full, er);
    vec_t v;
    v.rst = rst[0]; v.av = av[0]; v.ad = 4'(ad); v.adat = 8'(adat);
    v.li = li[0]; v.ld = 4'(ld); v.mv = mv[0]; v.md = 8'(md);
    v.rdy = rdy[0]; v.we = we[0]; v.ptr = 4'(ptr); v.di = 8'(di);
    v.bsy = 9'(bsy); v.full = full[0]; v.er = er[0];
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; ld_issue = 1'b0; mem_valid = 1'b0;
    alu_dst = '0; ld_dst = '0; alu_data = '0; mem_data = '0;
  endtask

  task automatic model_reset();
    q.delete(); m_busy = '0; m_we = 1'b0; m_ptr = '0; m_di = '0; m_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // behavioural reference: a return pops the oldest load, then ALU, then issue against
  // the queue as it stands after the pop
  task automatic model_edge();
    int d;
    bit xfer;
    xfer = mem_valid && !alu_valid && q.size() > 0;
    if (mem_valid && q.size() == 0) m_err = 1'b1;
    m_we = 1'b0;
    if (xfer) begin
      d = q.pop_front();
      m_busy[d] = 1'b0;
      m_we = 1'b1; m_ptr = 4'(d); m_di = mem_data;
    end
    if (alu_valid) begin
      if (int'(alu_dst) >= 9) m_err = 1'b1;
      else begin
        if (m_busy[alu_dst]) m_err = 1'b1;
        m_we = 1'b1; m_ptr = alu_dst; m_di = alu_data;
      end
    end
    if (ld_issue) begin
      if (int'(ld_dst) >= 9) m_err = 1'b1;
      else if (q.size() >= 4 || m_busy[ld_dst]) m_err = 1'b1;
      else begin
        q.push_back(int'(ld_dst));
        m_busy[ld_dst] = 1'b1;
      end
    end
  endtask

  task automatic cycle(input string tag);
    logic e_rdy;
    e_rdy = !alu_valid && q.size() > 0;
    #1;
    chk({tag, " mem_ready"}, 32'(mem_ready), 32'(e_rdy));
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk({tag, " rf_we"}, 32'(rf_we), 32'(m_we));
    if (m_we) begin
      chk({tag, " rf_ptr_w"}, 32'(rf_ptr_w), 32'(m_ptr));
      chk({tag, " rf_di"}, 32'(rf_di), 32'(m_di));
    end
    chk({tag, " busy"}, 32'(busy), 32'(m_busy));
    chk({tag, " ld_full"}, 32'(ld_full), 32'(q.size() == 4));
    chk({tag, " err"}, 32'(err), 32'(m_err));
  endtask

  initial begin
    // rst av ad adat li ld mv md | rdy we ptr di bsy full err
    add(0,1,3,'hA5,0,0,0,0,     0,1,3,'hA5,'h000,0,0);
    add(0,0,0,0,0,0,0,0,        0,0,3,'hA5,'h000,0,0);
    add(0,0,0,0,1,8,0,0,        0,0,3,'hA5,'h100,0,0);
    add(0,0,0,0,0,0,1,'h3C,     1,1,8,'h3C,'h000,0,0);
    add(0,0,0,0,1,1,0,0,        0,0,8,'h3C,'h002,0,0);
    add(0,0,0,0,1,2,0,0,        1,0,8,'h3C,'h006,0,0);
    add(0,0,0,0,1,4,0,0,        1,0,8,'h3C,'h016,0,0);
    add(0,0,0,0,1,5,0,0,        1,0,8,'h3C,'h036,1,0);
    add(0,0,0,0,1,6,0,0,        1,0,8,'h3C,'h036,1,1);
    add(0,0,0,0,0,0,1,'h11,     1,1,1,'h11,'h034,0,1);
    add(0,0,0,0,0,0,1,'h22,     1,1,2,'h22,'h030,0,1);
    add(0,0,0,0,0,0,1,'h44,     1,1,4,'h44,'h020,0,1);
    add(0,0,0,0,0,0,1,'h55,     1,1,5,'h55,'h000,0,1);
    add(1,0,0,0,1,2,0,0,        0,0,0,'h00,'h004,0,0);
    add(0,1,0,'h77,0,0,1,'h99,  0,1,0,'h77,'h004,0,0);
    add(0,0,0,0,0,0,1,'h99,     1,1,2,'h99,'h000,0,0);
    add(1,0,0,0,1,7,0,0,        0,0,0,'h00,'h080,0,0);
    add(0,1,7,'h5A,0,0,0,0,     0,1,7,'h5A,'h080,0,1);
    add(0,0,0,0,0,0,1,'hE1,     1,1,7,'hE1,'h000,0,1);
    add(1,0,0,0,1,3,0,0,        0,0,0,'h00,'h008,0,0);
    add(0,0,0,0,1,3,1,'h33,     1,1,3,'h33,'h008,0,0);
    add(0,0,0,0,0,0,1,'h44,     1,1,3,'h44,'h000,0,0);
    add(0,1,9,'h12,0,0,0,0,     0,0,3,'h44,'h000,0,1);
    add(1,0,0,0,1,1,0,0,        0,0,0,'h00,'h002,0,0);
    add(0,0,0,0,1,2,0,0,        1,0,0,'h00,'h006,0,0);
    add(0,0,0,0,1,3,0,0,        1,0,0,'h00,'h00E,0,0);
    add(0,0,0,0,1,4,0,0,        1,0,0,'h00,'h01E,1,0);
    add(0,0,0,0,1,5,1,'hAB,     1,1,1,'hAB,'h03C,1,0);
    add(0,0,0,0,0,0,1,'hCD,     1,1,2,'hCD,'h038,0,0);

    #12;
    chk("reset rf_we", 32'(rf_we), 32'd0);
    chk("reset rf_ptr_w", 32'(rf_ptr_w), 32'd0);
    chk("reset rf_di", 32'(rf_di), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ld_full", 32'(ld_full), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset mem_ready", 32'(mem_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      alu_valid = tbl[i].av; alu_dst = tbl[i].ad; alu_data = tbl[i].adat;
      ld_issue = tbl[i].li; ld_dst = tbl[i].ld;
      mem_valid = tbl[i].mv; mem_data = tbl[i].md;
      #1;
      chk($sformatf("v%0d mem_ready", i), 32'(mem_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d rf_we", i), 32'(rf_we), 32'(tbl[i].we));
      chk($sformatf("v%0d rf_ptr_w", i), 32'(rf_ptr_w), 32'(tbl[i].ptr));
      chk($sformatf("v%0d rf_di", i), 32'(rf_di), 32'(tbl[i].di));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("v%0d ld_full", i), 32'(ld_full), 32'(tbl[i].full));
      chk($sformatf("v%0d err", i), 32'(err), 32'(tbl[i].er));
      idle_inputs();
    end

    do_reset();
    for (int r = 1; r <= 3; r++) begin
      ld_issue = 1'b1; ld_dst = 4'(r);
      cycle("midrst issue");
    end
    idle_inputs();
    alu_valid = 1'b1; alu_dst = 4'd0; alu_data = 8'h5E;
    @(posedge clk);
    #1;
    chk("midrst inflight rf_we", 32'(rf_we), 32'd1);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("midrst rf_we", 32'(rf_we), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst ld_full", 32'(ld_full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    mem_valid = 1'b1; mem_data = 8'hC3;
    cycle("postrst memvalid");
    chk("postrst err", 32'(err), 32'd1);
    idle_inputs();

    for (int s = 0; s < 10; s++) begin
      do_reset();
      for (int c = 0; c < 200; c++) begin
        alu_valid = ($urandom_range(0, 2) == 0);
        alu_data = 8'($urandom);
        ld_issue = ($urandom_range(0, 1) == 1);
        mem_valid = ($urandom_range(0, 1) == 1);
        mem_data = 8'($urandom);
        if (s % 2 == 0) begin
          alu_dst = 4'($urandom_range(0, 8));
          ld_dst = 4'($urandom_range(0, 8));
          if (m_busy[alu_dst]) alu_valid = 1'b0;
          if (q.size() >= 4 || m_busy[ld_dst]) ld_issue = 1'b0;
          if (q.size() == 0) mem_valid = 1'b0;
        end else begin
          alu_dst = 4'($urandom_range(0, 9));
          ld_dst = 4'($urandom_range(0, 9));
        end
        cycle(s % 2 == 0 ? "rand legal" : "rand any");
      end
      idle_inputs();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
Write-side controller for the CPU register file. It merges ALU results and multi-cycle data-memory load returns into the single register-file write port (rf_we/rf_ptr_w/rf_di). It keeps an in-order queue of pending load destinations and a per-register busy scoreboard so that decode can stall on registers whose load is still outstanding. Register 8 (accumulator) is written like any other index.

Parameters:
DW, 8, data width of register-file entries
AW, 4, register index width
NREG, 9, number of architectural registers (0..8; 8 = accumulator)
QDEPTH, 4, pending-load queue depth (power of two)

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU result valid this cycle; always accepted
alu_dst  input  AW  ALU destination register
alu_data  input  DW  ALU result
ld_issue  input  1  load issued to memory this cycle
ld_dst  input  AW  destination register of issued load
mem_valid  input  1  load data returning from memory
mem_data  input  DW  returned load data
mem_ready  output  1  load return accepted this cycle (handshake with mem_valid)
rf_we  output  1  register-file write enable
rf_ptr_w  output  AW  register-file write index
rf_di  output  DW  register-file write data
busy  output  NREG  bit r = register r has an outstanding load
ld_full  output  1  pending-load queue full; ld_issue must not be asserted
err  output  1  sticky protocol-error flag

Behaviour:
- Reset (async, rst_n=0): rf_we=0, rf_ptr_w=0, rf_di=0, busy=0, err=0, queue empty (ld_full=0), mem_ready=0. Deassertion is synchronous to clk.
- Write latency: an accepted ALU result or load return appears on rf_we/rf_ptr_w/rf_di on the next posedge (registered), held for exactly one cycle. With no accept, rf_we=0; rf_ptr_w and rf_di hold their last values.
- Arbitration: the ALU has strict priority. mem_ready = !alu_valid && queue not empty (combinational). A load return transfers on mem_valid && mem_ready; otherwise memory holds its data.
- Load destination: the head of the queue. Loads return in issue order. A transfer pops the head.
- Issue: ld_issue && !ld_full && !busy[ld_dst] && ld_dst<NREG pushes ld_dst and sets busy[ld_dst] (visible the next cycle).
- Clear: a load-return transfer clears busy[head] in the same edge that registers the write.
- Same-cycle issue and return to the same register: clear then set, so busy stays 1. Queue count is unchanged.
- Push and pop in the same cycle when full: legal. ld_full stays 1.
- Queue pointers wrap modulo QDEPTH. ld_full = (count==QDEPTH).
- err is set (sticky until reset) on any of these:
  - ld_issue while ld_full (issue dropped)
  - ld_issue to a busy register (dropped)
  - ld_dst>=NREG or alu_dst>=NREG (op dropped, no write)
  - alu_valid to a busy register (WAW hazard; the write is still performed, busy unchanged)
  - mem_valid while the queue is empty (ignored)
- Reset mid-operation: the queue, busy bits and any pending write are discarded. No rf_we is asserted after reset assertion.

Decomposition:
- Package rf_pkg holds:
  - constants DW, AW, NREG, ACC_IDX=8
  - typedef reg_idx_t (logic [AW-1:0])
  - typedef data_t (logic [DW-1:0])
  - enum wb_src_e {WB_NONE, WB_ALU, WB_MEM}, which selects the registered write source
- One sub-module: ld_tag_fifo, a QDEPTH x AW synchronous FIFO with push/pop/head/count/full/empty and async active-low reset. The scoreboard and arbitration stay in rf_writeback.

Test Plan:
- Reset, then alu_valid=1, alu_dst=3, alu_data=8'hA5 for one cycle -> next cycle rf_we=1, rf_ptr_w=3, rf_di=A5. The cycle after, rf_we=0.
- ld_issue with ld_dst=8 -> busy[8]=1 next cycle. mem_valid with mem_data=8'h3C -> mem_ready=1, then rf_we=1, rf_ptr_w=8, rf_di=3C, and busy[8]=0 on the same edge.
- Issue loads to r1, r2, r4, r5 -> ld_full=1. A fifth issue to r6 -> err=1, busy[6]=0. Returns 11,22,44,55 write r1, r2, r4, r5 in that order.
- mem_valid=1 held while alu_valid=1 (alu_dst=0, 8'h77) with one load pending to r2 -> mem_ready=0 that cycle, ALU write to r0 first. The load writes r2 the following cycle.
- Pending load to r7, then alu_valid to r7 -> err=1. ALU write to r7 occurs, busy[7] stays 1. A later return overwrites r7.
- Assert rst_n=0 with 3 loads pending and a write in flight -> immediately rf_we=0, busy=0, ld_full=0. After release, mem_valid alone -> mem_ready=0 and err=1.
